// File: rtl/smart_cargo_tx_pkg.sv
// Shared types and constants for the cargo-elevator status transmitter.
// Framer/serialiser state codes, frame bytes and the ASCII hex helper.
package smart_cargo_tx_pkg;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ESPERA  = 4'd2,
    FIM     = 4'd3
  } framer_t;

  typedef enum logic [1:0] {
    REPOUSO,
    INICIO,
    DADOS,
    PARADA
  } ser_t;

  typedef struct packed {
    logic [1:0] andar;
    logic [1:0] prox;
    logic [3:0] flags;
  } snap_t;

  localparam logic [7:0] FRAME_SOF = 8'h23;
  localparam logic [7:0] FRAME_EOF = 8'h0A;
  localparam int         FRAME_LEN = 5;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9)
      return 8'h30 + {4'd0, n};
    else
      return 8'h37 + {4'd0, n};
  endfunction

endpackage

// File: rtl/smart_cargo_tx_status_if.sv
// Status inputs and serial/debug outputs of the status transmitter.
// master drives the snapshot inputs, slave is the transmitter.
interface smart_cargo_tx_status_if;
  logic       envia;
  logic [1:0] andar_atual;
  logic [1:0] prox_parada;
  logic [3:0] flags;
  logic       TX;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    output envia, andar_atual, prox_parada, flags,
    input  TX, ocupado, pronto, db_estado
  );

  modport slave (
    input  envia, andar_atual, prox_parada, flags,
    output TX, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/tx_serial_8n1.sv
// UART 8N1 byte serialiser, LSB first, idle high.
// done pulses in the last cycle of the stop bit.
module tx_serial_8n1
  import smart_cargo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dado,
  output logic       TX,
  output logic       done,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  ser_t          r_st, w_st_n;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_dado;
  logic          w_tick;

  assign w_tick = (r_cnt == LAST);
  assign busy   = (r_st != REPOUSO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st   <= REPOUSO;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_dado <= '0;
    end else begin
      r_st <= w_st_n;
      if (r_st == REPOUSO) begin
        r_cnt <= '0;
        r_bit <= '0;
        if (start) r_dado <= dado;
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        // bit index wraps 7->0 as the last data bit ends
        if (r_st == DADOS && w_tick) r_bit <= r_bit + 3'd1;
      end
    end
  end

  always_comb begin
    w_st_n = r_st;
    TX     = 1'b1;
    done   = 1'b0;
    unique case (r_st)
      REPOUSO: if (start) w_st_n = INICIO;
      INICIO: begin
        TX = 1'b0;
        if (w_tick) w_st_n = DADOS;
      end
      DADOS: begin
        TX = r_dado[r_bit];
        if (w_tick && r_bit == 3'd7) w_st_n = PARADA;
      end
      PARADA: begin
        if (w_tick) begin
          done   = 1'b1;
          w_st_n = REPOUSO;
        end
      end
      default: w_st_n = REPOUSO;
    endcase
  end

endmodule

// File: rtl/smart_cargo_tx_status.sv
// Elevator status framer: snapshots floor/stop/flags on an envia rise
// and sends "#", floor, stop, hex flags, LF over UART 8N1.
module smart_cargo_tx_status
  import smart_cargo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                    clock,
  input  logic                    reset,
  smart_cargo_tx_status_if.slave  bus
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  framer_t    r_st, w_st_n;
  logic       r_env_s, r_env_q, w_rise;
  logic       r_pend, w_pend_n;
  logic       w_load, w_inc;
  snap_t      r_snap;
  logic [2:0] r_idx;
  logic       r_start;
  logic [7:0] w_byte;
  logic       w_done, w_busy, w_tx;

  assign w_rise = r_env_s & ~r_env_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_env_s <= 1'b0;
      r_env_q <= 1'b0;
      r_st    <= OCIOSO;
      r_pend  <= 1'b0;
      r_snap  <= '0;
      r_idx   <= '0;
      r_start <= 1'b0;
    end else begin
      r_env_s <= bus.envia;
      r_env_q <= r_env_s;
      r_st    <= w_st_n;
      r_pend  <= w_pend_n;
      // start is registered so each byte gets a 2-cycle idle gap
      r_start <= (r_st == CARREGA);
      if (w_load) begin
        r_snap <= '{andar: bus.andar_atual,
                    prox:  bus.prox_parada,
                    flags: bus.flags};
        r_idx  <= '0;
      end else if (w_inc) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_st_n   = r_st;
    w_pend_n = r_pend;
    w_load   = 1'b0;
    w_inc    = 1'b0;
    unique case (r_st)
      OCIOSO: begin
        if (w_rise) begin
          w_load = 1'b1;
          w_st_n = CARREGA;
        end
      end
      CARREGA: begin
        if (w_rise) w_pend_n = 1'b1;
        w_st_n = ESPERA;
      end
      ESPERA: begin
        if (w_rise) w_pend_n = 1'b1;
        if (w_done) begin
          if (r_idx < LAST_IDX) begin
            w_inc  = 1'b1;
            w_st_n = CARREGA;
          end else begin
            w_st_n = FIM;
          end
        end
      end
      FIM: begin
        if (r_pend || w_rise) begin
          w_pend_n = 1'b0;
          w_load   = 1'b1;
          w_st_n   = CARREGA;
        end else begin
          w_st_n = OCIOSO;
        end
      end
      default: w_st_n = OCIOSO;
    endcase
  end

  always_comb begin
    unique case (r_idx)
      3'd0:    w_byte = FRAME_SOF;
      3'd1:    w_byte = 8'h30 + {6'd0, r_snap.andar};
      3'd2:    w_byte = 8'h30 + {6'd0, r_snap.prox};
      3'd3:    w_byte = hex_ascii(r_snap.flags);
      default: w_byte = FRAME_EOF;
    endcase
  end

  tx_serial_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock(clock),
    .reset(reset),
    .start(r_start),
    .dado (w_byte),
    .TX   (w_tx),
    .done (w_done),
    .busy (w_busy)
  );

  assign bus.TX        = w_tx;
  assign bus.pronto    = (r_st == FIM);
  assign bus.db_estado = r_st;
  assign bus.ocupado   = (r_st == CARREGA) || (r_st == ESPERA) ||
                         ((r_st == FIM) && (r_pend || w_rise));

endmodule

// File: tb/tb_smart_cargo_tx_status.sv
// Scoreboard bench: stimulus queues expected frames, a UART monitor
// decodes TX and checks bytes, bit widths and inter-byte gaps.
module tb_smart_cargo_tx_status;

  localparam int CPB        = 4;
  localparam int BYTE_CYC   = 10 * CPB;
  localparam int FRAME_BUSY = 2 + 5 * BYTE_CYC + 4 * 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smart_cargo_tx_status_if b4 ();
  smart_cargo_tx_status_if bb ();

  smart_cargo_tx_status #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (b4.slave)
  );

  smart_cargo_tx_status dut_big (
    .clock(clk),
    .reset(rst_n),
    .bus  (bb.slave)
  );

  int total = 0;
  int bad   = 0;
  int pronto_cnt = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [39:0] model(input int a, input int p,
                                        input int f);
    logic [7:0] h;
    if (f < 10) h = 8'(48 + f);
    else        h = 8'(65 + f - 10);
    return {8'h23, 8'(48 + a), 8'(48 + p), h, 8'h0A};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (b4.pronto === 1'b1) pronto_cnt++;
    end
  end

  initial begin
    int cnt, pos, gap;
    bit mbusy, werr;
    logic bv;
    logic [7:0] sh;
    logic [39:0] fr, e;
    mbusy = 0; pos = 0; gap = 0; cnt = 0; werr = 0;
    bv = 1'b1; sh = '0; fr = '0; e = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mbusy = 0; pos = 0; gap = 0; fr = '0;
      end else if (!mbusy) begin
        if (b4.TX === 1'b0) begin
          if (pos != 0) check("gap", gap, 2);
          mbusy = 1; cnt = 1; bv = 1'b0; werr = 0;
        end else begin
          gap++;
        end
      end else begin
        if (cnt % CPB == 0) begin
          bv = b4.TX;
          if (cnt / CPB >= 1 && cnt / CPB <= 8) sh[cnt / CPB - 1] = b4.TX;
        end else if (b4.TX !== bv) begin
          werr = 1;
        end
        cnt++;
        if (cnt == BYTE_CYC) begin
          check("bitwidth", werr, 0);
          check("stopbit", bv, 1);
          fr = {fr[31:0], sh};
          pos++;
          mbusy = 0;
          gap = 0;
          if (pos == 5) begin
            pos = 0;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_frame got=%0h want=none", fr);
            end else begin
              e = exp_q.pop_front();
              if (fr !== e) begin
                bad++;
                $display("FAIL frame got=%0h want=%0h", fr, e);
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int a, input int p, input int f);
    b4.andar_atual = 2'(a);
    b4.prox_parada = 2'(p);
    b4.flags       = 4'(f);
  endtask

  task automatic pulse();
    b4.envia = 1'b1;
    tick();
    b4.envia = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int hi);
    int n;
    bit seen;
    hi = 0; n = 0; seen = 0;
    while (n < budget) begin
      tick();
      n++;
      if (b4.ocupado === 1'b1) begin
        hi++;
        seen = 1;
      end else if (seen) begin
        break;
      end
    end
    if (n >= budget) check("idle_timeout", n, 0);
    repeat (3) tick();
  endtask

  task automatic run_frame(input int a, input int p, input int f);
    int hi, p0;
    set_in(a, p, f);
    exp_q.push_back(model(a, p, f));
    p0 = pronto_cnt;
    pulse();
    wait_idle(400, hi);
    check("ocupado_cycles", hi, FRAME_BUSY);
    check("pronto_one", pronto_cnt - p0, 1);
    check("idle_state", b4.db_estado, 0);
  endtask

  initial begin
    int hi, p0, falls, lat, w;
    logic prev;
    b4.envia = 0; bb.envia = 0;
    set_in(0, 0, 0);
    bb.andar_atual = 2'd1; bb.prox_parada = 2'd2; bb.flags = 4'd3;
    repeat (3) tick();
    check("rst_tx", b4.TX, 1);
    check("rst_ocupado", b4.ocupado, 0);
    check("rst_pronto", b4.pronto, 0);
    check("rst_db", b4.db_estado, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    run_frame(2, 3, 5);
    run_frame(0, 0, 11);
    run_frame(0, 0, 15);

    // snapshot: floor changes while byte0 is on the line
    set_in(1, 0, 0);
    exp_q.push_back(model(1, 0, 0));
    pulse();
    repeat (20) tick();
    set_in(3, 0, 0);
    wait_idle(400, hi);
    run_frame(3, 0, 0);

    // queueing: one pending frame, later rises dropped
    set_in(2, 1, 6);
    exp_q.push_back(model(2, 1, 6));
    p0 = pronto_cnt; hi = 0; falls = 0; prev = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c == 0 || c == 96 || c == 180 || c == 185) b4.envia = 1'b1;
      if (c == 1 || c == 97 || c == 181 || c == 186) b4.envia = 1'b0;
      if (c == 99) begin
        set_in(1, 3, 12);
        exp_q.push_back(model(1, 3, 12));
      end
      tick();
      if (b4.ocupado === 1'b1) hi++;
      if (prev === 1'b1 && b4.ocupado !== 1'b1) falls++;
      prev = b4.ocupado;
    end
    check("queue_busy", hi, 2 * FRAME_BUSY + 1);
    check("queue_falls", falls, 1);
    check("queue_pronto", pronto_cnt - p0, 2);

    // level-held envia gives a single frame
    set_in(0, 2, 9);
    exp_q.push_back(model(0, 2, 9));
    p0 = pronto_cnt;
    b4.envia = 1'b1;
    repeat (200) tick();
    b4.envia = 1'b0;
    repeat (300) tick();
    check("level_pronto", pronto_cnt - p0, 1);

    // reset in the middle of a data bit of byte1
    set_in(1, 2, 3);
    exp_q.push_back(model(1, 2, 3));
    p0 = pronto_cnt;
    pulse();
    repeat (55) tick();
    check("busy_before_rst", b4.ocupado, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_tx", b4.TX, 1);
    check("async_ocupado", b4.ocupado, 0);
    check("async_db", b4.db_estado, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_pronto", pronto_cnt - p0, 0);
    run_frame(3, 1, 10);

    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 15));

    // default bit rate: latency and start-bit width
    bb.envia = 1'b1;
    tick();
    bb.envia = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bb.TX === 1'b0) begin
        lat = i;
        break;
      end
    end
    check("latency_434", lat, 3);
    w = 0;
    while (bb.TX === 1'b0 && w < 2000) begin
      w++;
      tick();
    end
    check("startbit_434", w, 434);
    w = 0;
    while (bb.ocupado === 1'b1 && w < 30000) begin
      w++;
      tick();
    end
    check("big_idle", bb.ocupado, 0);

    repeat (10) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smart_cargo_tx_status.md
Name: smart_cargo_tx_status

Overview:
UART 8N1 transmitter that reports the cargo elevator's live status. It is the outbound counterpart of the RX destination-receive path. On each rising edge of a request it snapshots the current floor, next stop and motor/emergency flags. It then serialises the snapshot on TX as a fixed 5-byte ASCII frame, so a host terminal can follow the elevator. It sits beside the datapath in the smart_cargo top and is fed by the signals already shown on the 7-segment displays.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200, integer division); legal range ≥2.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
envia  in  1  send request; a frame is queued on its rising edge (level-high alone does nothing)
andar_atual  in  2  current floor 0..3
prox_parada  in  2  next stop 0..3
flags  in  4  bit0 motorSubindo, bit1 motorDescendo, bit2 emergencia, bit3 temDestino
TX  out  1  serial line, idle high
ocupado  out  1  high while a frame is in flight
pronto  out  1  one-cycle pulse at frame completion
db_estado  out  4  framer state code for the hexa7seg debug display

Behaviour:
- Reset (asynchronous, while reset=0): TX=1, ocupado=0, pronto=0, db_estado=0; edge detector, pending flag, snapshot, byte index and bit counters all cleared. Reset asserted mid-bit forces TX=1 immediately. The aborted frame produces no pronto.
- Edge detection: envia is registered each cycle; rise = envia & ~envia_q.
- Frame layout (per byte: LSB first, 1 start bit (0), 8 data bits, 1 stop bit (1)):
  - byte0: 0x23 ('#')
  - byte1: 0x30+andar_atual
  - byte2: 0x30+prox_parada
  - byte3: ASCII hex of flags, 0x30+f for f≤9, 0x37+f for f≥10
  - byte4: 0x0A
- Snapshot: andar_atual, prox_parada and flags are latched in the cycle the frame starts. Input changes during a frame do not affect it.
- Framer FSM (db_estado code in brackets):
  - OCIOSO[0]: on rise, latch the snapshot, set index=0, go to CARREGA. ocupado=1 from the next cycle.
  - CARREGA[1]: pulse start to the serialiser with byte[index], go to ESPERA.
  - ESPERA[2]: wait for serialiser done.
    - If index<4: index+1, go to CARREGA.
    - Else go to FIM.
  - FIM[3]: pronto=1 for this cycle only.
    - If pending: clear pending, re-snapshot, index=0, go to CARREGA. ocupado stays 1.
    - Else go to OCIOSO; ocupado=0 in this same cycle.
- Latency: TX falls to 0 on the 3rd clock edge after the edge that samples envia=1 (edge k samples the input; TX=0 after edge k+3). Each bit lasts exactly CLKS_PER_BIT cycles.
- Inter-byte gap: TX stays high for exactly 2 cycles between a stop bit's end and the next start bit (done→ESPERA exit→CARREGA→load).
- Simultaneous and boundary events:
  - A rise while ocupado=1 sets pending (a queue one deep).
  - Further rises while pending=1 are dropped.
  - A rise in the same cycle as FIM counts as pending.
- Serialiser: states REPOUSO, INICIO, DADOS, PARADA. It uses a bit-timer (width $clog2(CLKS_PER_BIT)) and a 3-bit bit index that wraps 7→0 on exit. done is a one-cycle pulse at the end of PARADA. A start pulse arriving outside REPOUSO is ignored.

Decomposition:
- Package smart_cargo_tx_pkg:
  - framer state encoding (4-bit codes above)
  - frame constants FRAME_SOF=8'h23, FRAME_EOF=8'h0A, FRAME_LEN=5
  - helper function for nibble→ASCII hex
- Sub-module tx_serial_8n1: ports clock, reset, start, dado[7:0], TX, done, busy. It is parameterised by CLKS_PER_BIT. The framer instantiates it once.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Basic frame: andar=2, prox=3, flags=4'b0101, one envia pulse → bytes 0x23,0x32,0x33,0x35,0x0A decoded. Every bit is 4 cycles wide, gaps are 2 cycles, exactly one pronto, ocupado high throughout.
- Hex letters: flags=4'hB, then 4'hF → byte3 = 0x42, then 0x46. With andar=0, prox=0 → 0x30, 0x30.
- Snapshot: andar changes 1→3 during byte0 → frame still carries 0x31. A second envia afterwards → 0x33.
- Queueing: envia rises during byte2, then rises twice more during byte4 → exactly two back-to-back frames and two pronto pulses. ocupado never drops between frames. No third frame.
- Edge sensitivity: envia held high 200 cycles → exactly one frame.
- Reset mid-frame: reset=0 in the middle of a data bit of byte1 → TX=1 within the same cycle (asynchronous), no pronto, db_estado=0. After release, a new envia gives a correct full frame.
- Timing at default CLKS_PER_BIT=434: start bit width measured as 434 cycles; latency from the sampling edge to the TX falling edge is 3 cycles.
